synapse_accumulator: RTL and testbench

- Producer side of the neuron input interface: turns a per-timestep input spike frame into the one-cycle in_valid / in_mac_sum pulse that neuron_body consumes.
- Holds a writable per-synapse weight table. For each accepted frame it walks all N_IN synapses, one per cycle, summing the weights of active inputs.
- Emits one saturated DATA_WIDTH-bit sum per frame. One instance sits directly in front of each neuron_body.

---
 rtl/snn_pkg.sv | 18 +
 rtl/synapse_accumulator_if.sv | 29 ++
 rtl/synapse_weight_rf.sv | 32 +++
 rtl/synapse_accumulator.sv | 101 ++++++++++
 tb/tb_synapse_accumulator.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared SNN constants, FSM encodings and saturation helper
package snn_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_WEIGHT_WIDTH = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  // Clamp an unsigned value to the largest number representable in width bits
  function automatic logic [31:0] sat_to_width(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/synapse_accumulator_if.sv
// rtl/synapse_accumulator_if.sv - frame, weight-write and neuron-side signals of the accumulator
interface synapse_accumulator_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int N_IN         = 16,
  parameter int ADDR_WIDTH   = 4
);

  logic                    in_frame_valid;
  logic [N_IN-1:0]         in_spikes;
  logic                    in_ready;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [WEIGHT_WIDTH-1:0] w_data;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_mac_sum;
  logic                    frame_drop;

  modport master (
    output in_frame_valid, in_spikes, w_we, w_addr, w_data,
    input  in_ready, out_valid, out_mac_sum, frame_drop
  );

  modport slave (
    input  in_frame_valid, in_spikes, w_we, w_addr, w_data,
    output in_ready, out_valid, out_mac_sum, frame_drop
  );

endinterface

// File: rtl/synapse_weight_rf.sv
// rtl/synapse_weight_rf.sv - per-synapse weight table, one sync write port and one comb read port
module synapse_weight_rf #(
  parameter int N_IN         = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [WEIGHT_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [WEIGHT_WIDTH-1:0] rdata
);

  logic [WEIGHT_WIDTH-1:0] regs [N_IN];

  // Write decode per entry; addresses beyond N_IN-1 match no entry and are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (we && (waddr == ADDR_WIDTH'(i))) regs[i] <= wdata;
      end
    end
  end

  // A same-cycle write is not visible here until the next cycle
  assign rdata = regs[raddr];

endmodule

// File: rtl/synapse_accumulator.sv
// rtl/synapse_accumulator.sv - walks a latched spike frame and emits one saturated weight sum per frame
module synapse_accumulator
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH,
  parameter int N_IN         = 16,
  parameter int ADDR_WIDTH   = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  synapse_accumulator_if.slave bus
);

  // Wide enough for N_IN full-scale weights, so no internal wrap
  localparam int ACC_WIDTH = WEIGHT_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(N_IN - 1);

  logic [1:0]              state;
  logic [ADDR_WIDTH-1:0]   index;
  logic [N_IN-1:0]         frame;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    acc_next;
  logic [WEIGHT_WIDTH-1:0] rd_weight;
  logic [DATA_WIDTH-1:0]   sat_sum;
  logic                    out_valid_q;
  logic [DATA_WIDTH-1:0]   sum_q;
  logic                    drop_q;

  synapse_weight_rf #(
    .N_IN        (N_IN),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_weight_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (bus.w_we),
    .waddr(bus.w_addr),
    .wdata(bus.w_data),
    .raddr(index),
    .rdata(rd_weight)
  );

  // Running sum including the synapse visited this cycle
  always_comb begin
    acc_next = acc;
    if (frame[index]) acc_next = acc + ACC_WIDTH'(rd_weight);
  end

  assign sat_sum = DATA_WIDTH'(sat_to_width(32'(acc_next), DATA_WIDTH));

  // Frame sequencing: accept in idle, one synapse per cycle, then a one-cycle emit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      index       <= '0;
      frame       <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_frame_valid) begin
            frame <= bus.in_spikes;
            acc   <= '0;
            index <= '0;
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc <= acc_next;
          if (index == LAST_INDEX) begin
            // Sum is registered on entry to emit so out_valid lines up with S_EMIT
            out_valid_q <= 1'b1;
            sum_q       <= sat_sum;
            index       <= '0;
            state       <= S_EMIT;
          end else begin
            index <= index + 1'b1;
          end
        end
        S_EMIT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Frames offered while busy are discarded and flagged one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else        drop_q <= bus.in_frame_valid && (state != S_IDLE);
  end

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_mac_sum = sum_q;
  assign bus.frame_drop  = drop_q;

endmodule

// File: tb/tb_synapse_accumulator.sv
// tb/tb_synapse_accumulator.sv - directed self-checking bench for synapse_accumulator
module tb_synapse_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int nvec = 0;
  int nerr = 0;

  int         lat;
  logic [7:0] sum;
  int         pulses;
  int         drops;
  int         drop_at;
  logic       rdy1;
  logic       rdy18;

  synapse_accumulator_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .N_IN(16), .ADDR_WIDTH(4)) bus ();

  synapse_accumulator #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .N_IN(16), .ADDR_WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_w(input logic [3:0] a, input logic [7:0] d);
    bus.w_we   = 1'b1;
    bus.w_addr = a;
    bus.w_data = d;
    tick();
    bus.w_we   = 1'b0;
  endtask

  // Offer frame sp at cycle T (now), optionally a weight write at cycle wcyc and a
  // second frame sp2 at cycle ocyc; observe n cycles, ending at cycle T+n.
  task automatic send_frame(input logic [15:0] sp, input int n,
                            input int wcyc, input logic [3:0] wa, input logic [7:0] wd,
                            input int ocyc, input logic [15:0] sp2);
    lat = -1; sum = 8'hxx; pulses = 0; drops = 0; drop_at = -1; rdy1 = 1'bx; rdy18 = 1'bx;
    for (int k = 0; k < n; k++) begin
      bus.in_frame_valid = (k == 0) || (k == ocyc);
      bus.in_spikes      = (k == ocyc) ? sp2 : sp;
      bus.w_we           = (k == wcyc);
      bus.w_addr         = wa;
      bus.w_data         = wd;
      tick();
      if (bus.out_valid) begin
        pulses++;
        lat = k + 1;
        sum = bus.out_mac_sum;
      end
      if (bus.frame_drop) begin
        drops++;
        drop_at = k + 1;
      end
      if (k + 1 == 1)  rdy1  = bus.in_ready;
      if (k + 1 == 18) rdy18 = bus.in_ready;
    end
    bus.in_frame_valid = 1'b0;
    bus.in_spikes      = '0;
    bus.w_we           = 1'b0;
  endtask

  initial begin
    bus.in_frame_valid = 1'b0;
    bus.in_spikes      = '0;
    bus.w_we           = 1'b0;
    bus.w_addr         = '0;
    bus.w_data         = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_mac_sum", bus.out_mac_sum, 0);
    chk("reset_frame_drop", bus.frame_drop, 0);

    for (int i = 0; i < 16; i++) write_w(4'(i), 8'(i + 1));

    send_frame(16'h0005, 20, -1, 4'd0, 8'd0, -1, 16'h0);
    chk("sum5_value", sum, 4);
    chk("sum5_latency", lat, 17);
    chk("sum5_pulses", pulses, 1);
    chk("sum5_busy_at_t1", rdy1, 0);
    chk("sum5_ready_at_t18", rdy18, 1);

    send_frame(16'hFFFF, 20, -1, 4'd0, 8'd0, -1, 16'h0);
    chk("full_value", sum, 136);
    chk("full_pulses", pulses, 1);
    chk("full_latency", lat, 17);

    send_frame(16'h0000, 20, -1, 4'd0, 8'd0, -1, 16'h0);
    chk("zero_value", sum, 0);
    chk("zero_latency", lat, 17);

    for (int i = 0; i < 16; i++) write_w(4'(i), 8'd200);
    send_frame(16'h0003, 20, -1, 4'd0, 8'd0, -1, 16'h0);
    chk("sat_value", sum, 255);

    send_frame(16'h0001, 18, -1, 4'd0, 8'd0, 5, 16'h0003);
    chk("drop_count", drops, 1);
    chk("drop_cycle", drop_at, 6);
    chk("drop_pulses", pulses, 1);
    chk("drop_value", sum, 200);
    send_frame(16'h0001, 20, -1, 4'd0, 8'd0, -1, 16'h0);
    chk("after_drop_latency", lat, 17);
    chk("after_drop_value", sum, 200);

    write_w(4'd3, 8'd10);
    send_frame(16'h0008, 20, 4, 4'd3, 8'd50, -1, 16'h0);
    chk("collision_old_value", sum, 10);
    send_frame(16'h0008, 20, -1, 4'd0, 8'd0, -1, 16'h0);
    chk("collision_new_value", sum, 50);

    send_frame(16'h0400, 20, 2, 4'd10, 8'd33, -1, 16'h0);
    chk("ahead_write_value", sum, 33);

    bus.in_frame_valid = 1'b1;
    bus.in_spikes      = 16'hFFFF;
    tick();
    bus.in_frame_valid = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", bus.out_valid, 0);
    chk("midreset_out_mac_sum", bus.out_mac_sum, 0);
    chk("midreset_in_ready", bus.in_ready, 1);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    chk("midreset_no_pulse", pulses, 0);
    chk("midreset_ready_after", bus.in_ready, 1);

    send_frame(16'hFFFF, 20, -1, 4'd0, 8'd0, -1, 16'h0);
    chk("post_reset_weights_cleared", sum, 0);
    chk("post_reset_latency", lat, 17);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
